// File: rtl/load_store_unit_pkg.sv
// Shared constants, state encoding and access-legality helper for the
// RV32I load/store unit and its load-alignment datapath.
package load_store_unit_pkg;
  localparam int DATA_WIDTH = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Illegal funct3 or a halfword/word access off its natural alignment.
  function automatic logic access_fault(input logic       is_store,
                                        input logic [2:0] funct3,
                                        input logic [1:0] off);
    logic illegal;
    logic misal;
    if (is_store) illegal = !(funct3 inside {F3_B, F3_H, F3_W});
    else          illegal = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    misal = ((funct3[1:0] == 2'b01) && off[0]) ||
            ((funct3[1:0] == 2'b10) && (off != 2'b00));
    return illegal || misal;
  endfunction
endpackage

// File: rtl/load_align.sv
// Combinational load-lane extraction and sign/zero extension of a read word.
module load_align
  import load_store_unit_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            addr,
  input  logic [2:0]            funct3,
  output logic [DATA_WIDTH-1:0] result
);
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = rdata[8*addr +: 8];
  assign half_lane = addr[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    result = '0;
    case (funct3)
      F3_B:    result = {{24{byte_lane[7]}}, byte_lane};
      F3_BU:   result = {24'd0, byte_lane};
      F3_H:    result = {{16{half_lane[15]}}, half_lane};
      F3_HU:   result = {16'd0, half_lane};
      F3_W:    result = rdata;
      default: result = '0;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one op per transaction, req/ack to data
// memory, store lane formatting and aligned load result for writeback.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_is_store,
  input  logic [2:0]            i_funct3,
  input  logic [DATA_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_store_data,
  output logic                  o_dmem_req,
  output logic                  o_dmem_we,
  output logic [DATA_WIDTH-1:0] o_dmem_addr,
  output logic [DATA_WIDTH-1:0] o_dmem_wdata,
  output logic [3:0]            o_dmem_wstrb,
  input  logic                  i_dmem_ack,
  input  logic [DATA_WIDTH-1:0] i_dmem_rdata,
  output logic                  o_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_load_data,
  output logic                  o_fault
);
  state_t                state, nxt;
  logic                  accept, fault_in;
  logic                  is_store_q;
  logic [2:0]            funct3_q;
  logic [1:0]            off_q;
  logic [3:0]            wstrb_d;
  logic [DATA_WIDTH-1:0] wdata_d, aligned;

  assign accept      = i_req_valid && (state == IDLE);
  assign fault_in    = access_fault(i_is_store, i_funct3, i_addr[1:0]);
  assign o_req_ready = (state == IDLE);
  assign o_dmem_req  = (state == REQ);
  assign o_rsp_valid = (state == RESP);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (i_req_valid) nxt = fault_in ? RESP : REQ;
      REQ:     if (i_dmem_ack)  nxt = RESP;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    wstrb_d = 4'b1111;
    wdata_d = i_store_data;
    case (i_funct3[1:0])
      2'b00: begin
        wstrb_d = 4'b0001 << i_addr[1:0];
        wdata_d = {4{i_store_data[7:0]}};
      end
      2'b01: begin
        wstrb_d = i_addr[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{i_store_data[15:0]}};
      end
      default: ;
    endcase
    if (!i_is_store) wstrb_d = 4'b0000;
  end

  // dmem outputs are captured at accept so they stay stable for the whole REQ phase.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      is_store_q   <= 1'b0;
      funct3_q     <= '0;
      off_q        <= '0;
      o_dmem_we    <= 1'b0;
      o_dmem_addr  <= '0;
      o_dmem_wdata <= '0;
      o_dmem_wstrb <= '0;
      o_load_data  <= '0;
      o_fault      <= 1'b0;
    end else if (accept) begin
      is_store_q  <= i_is_store;
      funct3_q    <= i_funct3;
      off_q       <= i_addr[1:0];
      o_fault     <= fault_in;
      o_load_data <= '0;
      if (!fault_in) begin
        o_dmem_we    <= i_is_store;
        o_dmem_addr  <= {i_addr[DATA_WIDTH-1:2], 2'b00};
        o_dmem_wdata <= wdata_d;
        o_dmem_wstrb <= wstrb_d;
      end
    end else if ((state == REQ) && i_dmem_ack && !is_store_q) begin
      o_load_data <= aligned;
    end
  end

  load_align u_align (
    .rdata  (i_dmem_rdata),
    .addr   (off_q),
    .funct3 (funct3_q),
    .result (aligned)
  );
endmodule

// File: tb/tb_load_store_unit.sv
// Directed table plus randomized ops for load_store_unit, checked against
// an arithmetic reference model of the access rules.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0, store_data = '0;
  logic        dmem_req, dmem_we, dmem_ack = 1'b0;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
  logic [3:0]  dmem_wstrb;
  logic        rsp_valid, fault;
  logic [31:0] load_data;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_is_store(is_store), .i_funct3(funct3), .i_addr(addr), .i_store_data(store_data),
    .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .o_dmem_addr(dmem_addr),
    .o_dmem_wdata(dmem_wdata), .o_dmem_wstrb(dmem_wstrb), .i_dmem_ack(dmem_ack),
    .i_dmem_rdata(dmem_rdata), .o_rsp_valid(rsp_valid), .o_load_data(load_data),
    .o_fault(fault)
  );

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          waits;
    logic        fault;
    logic [31:0] ld;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: access size in bytes, legality, lane math.
  function automatic int access_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic model_fault(input logic st, input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if (!legal) return 1'b1;
    return (a % access_size(f3)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
    longint unsigned mask, v;
    int sz;
    sz   = access_size(f3);
    mask = (64'd1 << (8 * sz)) - 1;
    v    = (longint'(rd) >> (8 * (a % 4))) & mask;
    if (f3[2] == 1'b0 && sz < 4 && v >= (mask + 1) / 2) v = v | (~mask);
    return v[31:0];
  endfunction

  function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [31:0] a);
    int s;
    s = ((1 << access_size(f3)) - 1) << (a % 4);
    return s[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
    logic [31:0] w;
    int sz;
    sz = access_size(f3);
    w  = '0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % sz) +: 8];
    return w;
  endfunction

  function automatic vec_t make_model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] sd, input logic [31:0] rd, input int w);
    vec_t v;
    v.st = st; v.f3 = f3; v.addr = a; v.sdata = sd; v.rdata = rd; v.waits = w;
    v.fault = model_fault(st, f3, a);
    v.ld    = (st || v.fault) ? 32'd0 : model_load(f3, a, rd);
    v.strb  = st ? model_strb(f3, a) : 4'b0000;
    v.wdata = model_wdata(f3, sd);
    return v;
  endfunction

  // Drive one op from IDLE through response; every wait is a fixed count.
  task automatic run_op(input vec_t v);
    @(negedge clk);
    chk("ready_before", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; is_store = v.st; funct3 = v.f3; addr = v.addr; store_data = v.sdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (v.fault) begin
      chk("flt_rsp", {31'd0, rsp_valid}, 32'd1);
      chk("flt_flag", {31'd0, fault}, 32'd1);
      chk("flt_ld", load_data, 32'd0);
      chk("flt_noreq", {31'd0, dmem_req}, 32'd0);
      @(posedge clk); #1;
      chk("flt_noreq2", {31'd0, dmem_req}, 32'd0);
    end else begin
      chk("req_hi", {31'd0, dmem_req}, 32'd1);
      chk("req_addr", dmem_addr, v.addr & 32'hFFFF_FFFC);
      chk("req_we", {31'd0, dmem_we}, {31'd0, v.st});
      chk("req_strb", {28'd0, dmem_wstrb}, {28'd0, v.strb});
      if (v.st) chk("req_wdata", dmem_wdata, v.wdata);
      for (int i = 0; i < v.waits; i++) begin
        @(posedge clk); #1;
        chk("wait_req", {31'd0, dmem_req}, 32'd1);
        chk("wait_norsp", {31'd0, rsp_valid}, 32'd0);
        chk("wait_addr", dmem_addr, v.addr & 32'hFFFF_FFFC);
      end
      dmem_ack = 1'b1; dmem_rdata = v.rdata;
      @(posedge clk); #1;
      dmem_ack = 1'b0; dmem_rdata = $urandom;
      chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("rsp_fault", {31'd0, fault}, 32'd0);
      chk("rsp_ld", load_data, v.ld);
      chk("rsp_noreq", {31'd0, dmem_req}, 32'd0);
      chk("rsp_notready", {31'd0, req_ready}, 32'd0);
    end
    @(posedge clk); #1;
    chk("rsp_pulse_end", {31'd0, rsp_valid}, 32'd0);
    chk("ready_after", {31'd0, req_ready}, 32'd1);
  endtask

  vec_t tbl[13];
  vec_t rv;

  initial begin
    tbl[0]  = '{1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 2, 1'b0, 32'hDEADBEEF, 4'b0000, 32'h0};
    tbl[1]  = '{1'b0, 3'b000, 32'h203, 32'h0,        32'h80FF1234, 1, 1'b0, 32'hFFFFFF80, 4'b0000, 32'h0};
    tbl[2]  = '{1'b0, 3'b100, 32'h203, 32'h0,        32'h80FF1234, 0, 1'b0, 32'h00000080, 4'b0000, 32'h0};
    tbl[3]  = '{1'b0, 3'b101, 32'h202, 32'h0,        32'h80FF1234, 0, 1'b0, 32'h000080FF, 4'b0000, 32'h0};
    tbl[4]  = '{1'b0, 3'b001, 32'h202, 32'h0,        32'h80FF1234, 1, 1'b0, 32'hFFFF80FF, 4'b0000, 32'h0};
    tbl[5]  = '{1'b1, 3'b000, 32'h5,   32'h000000AB, 32'h0,        1, 1'b0, 32'h0, 4'b0010, 32'hABABABAB};
    tbl[6]  = '{1'b1, 3'b001, 32'h6,   32'h00001234, 32'h0,        0, 1'b0, 32'h0, 4'b1100, 32'h12341234};
    tbl[7]  = '{1'b0, 3'b010, 32'h102, 32'h0,        32'h0,        0, 1'b1, 32'h0, 4'b0000, 32'h0};
    tbl[8]  = '{1'b0, 3'b011, 32'h100, 32'h0,        32'h0,        0, 1'b1, 32'h0, 4'b0000, 32'h0};
    tbl[9]  = '{1'b0, 3'b010, 32'h300, 32'h0,        32'h12345678, 0, 1'b0, 32'h12345678, 4'b0000, 32'h0};
    tbl[10] = '{1'b1, 3'b010, 32'h10,  32'hCAFEF00D, 32'h0,        0, 1'b0, 32'h0, 4'b1111, 32'hCAFEF00D};
    tbl[11] = '{1'b1, 3'b100, 32'h10,  32'h1,        32'h0,        0, 1'b1, 32'h0, 4'b0000, 32'h0};
    tbl[12] = '{1'b0, 3'b001, 32'h201, 32'h0,        32'h0,        0, 1'b1, 32'h0, 4'b0000, 32'h0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_we", {31'd0, dmem_we}, 32'd0);
    chk("rst_strb", {28'd0, dmem_wstrb}, 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("rst_ld", load_data, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < 13; i++) run_op(tbl[i]);

    // Reset during REQ with the ack still outstanding, then a stray late ack.
    @(negedge clk);
    req_valid = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h400;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("abort_req_hi", {31'd0, dmem_req}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_req_drop", {31'd0, dmem_req}, 32'd0);
    chk("abort_norsp", {31'd0, rsp_valid}, 32'd0);
    rst_n = 1'b1;
    dmem_ack = 1'b1; dmem_rdata = 32'h55AA55AA;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    chk("late_ack_norsp", {31'd0, rsp_valid}, 32'd0);
    chk("late_ack_noreq", {31'd0, dmem_req}, 32'd0);
    chk("late_ack_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    chk("late_ack_norsp2", {31'd0, rsp_valid}, 32'd0);
    run_op(tbl[9]);

    for (int n = 0; n < 60; n++) begin
      rv = make_model($urandom_range(0, 1), 3'($urandom_range(0, 7)), $urandom,
                      $urandom, $urandom, $urandom_range(0, 3));
      run_op(rv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit of the RV32I core. It accepts one load or store per transaction from execute and runs a req/ack handshake with data memory. It aligns store data into byte strobes and extracts/sign-extends load data. The aligned result is delivered as the load-data input of the writeback-select 4:1 mux, alongside a one-cycle response strobe and a fault flag.

## Interface
- DATA_WIDTH, `DATA_WIDTH (32): data/address width; only 32 is supported.
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_req_valid  in  1  execute presents a memory op.
- o_req_ready  out  1  unit can accept; high only in IDLE.
- i_is_store  in  1  1 = store, 0 = load.
- i_funct3  in  3  RV32I funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
- i_addr  in  32  byte address (rs1 + imm).
- i_store_data  in  32  rs2 value.
- o_dmem_req  out  1  memory request; held until ack.
- o_dmem_we  out  1  write enable.
- o_dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- o_dmem_wdata  out  32  lane-replicated store data.
- o_dmem_wstrb  out  4  byte strobes.
- i_dmem_ack  in  1  memory completes the request this cycle.
- i_dmem_rdata  in  32  read word; valid when i_dmem_ack is high.
- o_rsp_valid  out  1  one-cycle completion pulse.
- o_load_data  out  32  aligned, extended load result (writeback mux input).
- o_fault  out  1  misaligned or illegal funct3; qualified by o_rsp_valid.

## Operation
- States: IDLE, REQ, RESP.
- IDLE: o_req_ready=1. If i_req_valid, latch is_store, funct3, addr, store_data.
  - Legal access: go to REQ.
  - Fault: go to RESP with fault=1; no memory access.
- REQ: o_dmem_req=1. All dmem outputs come from latched registers and stay stable. On i_dmem_ack, capture i_dmem_rdata (loads only) and go to RESP.
- RESP: o_rsp_valid=1 for exactly one cycle, then IDLE. No backpressure; writeback always consumes.
- Misalignment faults:
  - halfword ops with addr[0]=1.
  - word ops with addr[1:0]!=00.
- Illegal funct3 faults:
  - loads: 011, 110, 111.
  - stores: any funct3 other than 000/001/010.
- Store strobes/data:
  - SB: wstrb=4'b0001<<addr[1:0], wdata={4{byte}}.
  - SH: wstrb=addr[1]?1100:0011, wdata={2{half}}.
  - SW: wstrb=1111, wdata=store_data.
- Load extraction: select byte/half lane by latched addr[1:0].
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW: word as-is.
- o_load_data is 0 for stores and faults.
- Loads drive o_dmem_we=0 and o_dmem_wstrb=0000.

## Timing
- Reset (i_rst_n=0 at an edge): state=IDLE. o_dmem_req=0, o_dmem_we=0, o_dmem_wstrb=0, o_dmem_addr=0, o_dmem_wdata=0, o_rsp_valid=0, o_load_data=0, o_fault=0. o_req_ready=1 after reset releases.
- Reset mid-transaction (REQ or RESP): abort, drop o_dmem_req next edge, emit no response. An ack arriving in IDLE is ignored.
- Accept at edge N → o_dmem_req high during cycle N+1.
- Ack sampled high during cycle N+k (k≥1, zero-wait ack allowed in N+1) → o_rsp_valid high in cycle N+k+1.
- Minimum latency from accept to response is 2 cycles; throughput is one op per 3 cycles minimum.
- Fault path: accept at N → o_rsp_valid/o_fault in N+1; o_dmem_req never asserts.
- o_load_data and o_fault are registered and stable through the o_rsp_valid cycle.
- i_req_valid is ignored outside IDLE; execute holds it until ready.

## Structure
- Shared header/package: `DATA_WIDTH; funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU); state encoding (IDLE/REQ/RESP, 2 bits).
- One combinational sub-module, load_align: inputs rdata, addr[1:0], funct3; output 32-bit extended result. Reusable by a later cache path.
- Store-lane formatting stays inline in load_store_unit.

## Test plan
- LW addr 0x100, ack after 2 wait cycles, rdata 0xDEADBEEF → dmem_addr 0x100, we=0; rsp_valid one cycle after ack; load_data 0xDEADBEEF, fault 0.
- LB addr 0x203, rdata 0x80FF_1234 → 0xFFFFFF80. Same access as LBU → 0x00000080. LHU addr 0x202 → 0x000080FF.
- SB addr 0x5, data 0x000000AB → dmem_addr 0x4, wstrb 0010, wdata 0xABABABAB, we=1. SH addr 0x6, data 0x1234 → wstrb 1100, wdata 0x12341234.
- LW addr 0x102 → rsp_valid and fault in cycle N+1, dmem_req never high. Load funct3 011 → same fault response.
- Zero-wait ack (ack in N+1) → rsp_valid in N+2. Back-to-back ops → ready returns in N+3, second op accepted.
- Reset asserted during REQ with ack pending → req drops, no rsp_valid. A late ack in IDLE causes no response; the next op completes normally.
